// File: rtl/pmu_pkg.sv
// pmu_pkg: shared state, command and tag-state codes for the power manage unit.
// Pulse inputs (*_done, *_req, *_off, new_cmd) are high for exactly one cycle;
// vee_rdy, cmd_head and tag_state are levels sampled on every clock edge.
package pmu_pkg;

    // FSM state codes; the guard states sit at 8/9 so existing debug decoders keep 0..4.
    typedef enum logic [3:0] {
        ST_RDY  = 4'd0,
        ST_INIT = 4'd1,
        ST_REC  = 4'd2,
        ST_SCU  = 4'd3,
        ST_OCU  = 4'd4,
        ST_GRD1 = 4'd8,
        ST_GRD2 = 4'd9,
        ST_END  = 4'd15
    } pmu_state_t;

    // Parsed command codes
    localparam logic [4:0] CMD_QUERYREP = 5'd3;
    localparam logic [4:0] CMD_ACK      = 5'd4;
    localparam logic [4:0] CMD_QUERY    = 5'd10;
    localparam logic [4:0] CMD_QUERYADJ = 5'd11;
    localparam logic [4:0] CMD_SELECT   = 5'd12;
    localparam logic [4:0] CMD_NAK      = 5'd20;
    localparam logic [4:0] CMD_REQ_RN   = 5'd21;
    localparam logic [4:0] CMD_READ     = 5'd22;
    localparam logic [4:0] CMD_WRITE    = 5'd23;
    localparam logic [4:0] CMD_KILL     = 5'd24;
    localparam logic [4:0] CMD_LOCK     = 5'd25;

    // Tag state codes
    localparam logic [3:0] TS_READY        = 4'd1;
    localparam logic [3:0] TS_ARBITRATE    = 4'd2;
    localparam logic [3:0] TS_REPLY        = 4'd3;
    localparam logic [3:0] TS_ACKNOWLEDGED = 4'd4;
    localparam logic [3:0] TS_OPEN         = 4'd5;
    localparam logic [3:0] TS_SECURED      = 4'd6;
    localparam logic [3:0] TS_KILLED       = 4'd7;
    localparam logic [3:0] TS_HALF_KILLED  = 4'd8;
    localparam logic [3:0] TS_HALF_SECURED = 4'd9;

    // Commands that will program the EEPROM and therefore need the VEE supply.
    function automatic logic wr_come_f(input logic [4:0] cmd, input logic [3:0] ts);
        return (cmd == CMD_WRITE) || (cmd == CMD_LOCK) ||
               ((cmd == CMD_KILL) && (ts == TS_HALF_KILLED));
    endfunction

endpackage

// File: rtl/pmu_dly_cnt.sv
// pmu_dly_cnt: loadable up/down counter with clear and a terminal-count compare.
module pmu_dly_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_srst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Clear beats load beats count; the count only moves while enabled.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= i_up ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
        end
    end

    assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/pmu_gen2.sv
// pmu_gen2: stage sequencer, clock-gate control and VEE power check for the tag core.
module pmu_gen2
    import pmu_pkg::*;
#(
    parameter int GUARD1   = 3,
    parameter int GUARD2   = 4,
    parameter int TO_W     = 12,
    parameter int TO_MAX   = 4095,
    parameter int VCHK_WIN = 8
) (
    input  logic       DOUB_BLF,
    input  logic       rst,
    input  logic       tag_status,
    input  logic       init_done,
    input  logic       parse_done,
    input  logic       parse_err,
    input  logic       scu_done,
    input  logic       ocu_done,
    input  logic       dec_done,
    input  logic       new_cmd,
    input  logic       par_div_req,
    input  logic       par_div_off,
    input  logic       ie_60k_req,
    input  logic       ie_60k_off,
    input  logic [4:0] cmd_head,
    input  logic [3:0] tag_state,
    input  logic       vee_rdy,
    output logic       init_en,
    output logic       dec_en,
    output logic       scu_en,
    output logic       ocu_en,
    output logic       div_en,
    output logic       K60_EN,
    output logic       vee_req,
    output logic       vchk_en,
    output logic       vee_err,
    output logic       stage_to,
    output logic [3:0] pmu_state_o
);

    localparam int GW = $clog2(((GUARD1 > GUARD2) ? GUARD1 : GUARD2) + 1);
    localparam logic [GW-1:0] G1_LOAD = GW'(GUARD1 - 1);
    localparam logic [GW-1:0] G2_LOAD = GW'(GUARD2 - 1);
    // Watchdog fires in the TO_MAX-th cycle of a stage (count starts at 0 on entry).
    localparam logic [TO_W-1:0] WD_TC = TO_W'((TO_MAX == 0) ? 0 : (TO_MAX - 1));
    localparam int SW = $clog2(VCHK_WIN + 1);
    localparam logic [SW-1:0] VCHK_FULL = SW'(VCHK_WIN);

    pmu_state_t r_state, w_state_next;
    logic          w_grd_load, w_grd_en, w_grd_tc;
    logic [GW-1:0] w_grd_load_val;
    logic          w_wd_clr, w_wd_tc, w_in_stage, w_stage_done, w_to_fire;
    logic          w_wr_come, w_vee_ok;
    logic          r_div_en, r_k60_en, r_vee_req, r_vchk_en, r_vee_err, r_stage_to;
    logic [SW-1:0] r_stab;

    assign w_in_stage   = (r_state == ST_SCU) || (r_state == ST_OCU);
    assign w_stage_done = ((r_state == ST_SCU) && scu_done) || ((r_state == ST_OCU) && ocu_done);
    // A done pulse in the expiry cycle wins, and a kill request pre-empts the timeout.
    assign w_to_fire    = (TO_MAX != 0) && w_in_stage && w_wd_tc && !w_stage_done && !tag_status;
    assign w_wr_come    = wr_come_f(cmd_head, tag_state);
    assign w_vee_ok     = (r_stab == VCHK_FULL);

    // State register; reset also overrides any pending kill request.
    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            r_state <= ST_RDY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; tag_status is applied last so it overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RDY:  w_state_next = ST_INIT;
            ST_INIT: if (init_done) w_state_next = ST_REC;
            ST_REC:  if (parse_done && !parse_err) w_state_next = ST_GRD1;
            ST_GRD1: if (w_grd_tc) w_state_next = ST_SCU;
            ST_SCU: begin
                if (scu_done) w_state_next = ST_GRD2;
                else if (w_to_fire) w_state_next = ST_REC;
            end
            ST_GRD2: if (w_grd_tc) w_state_next = ST_OCU;
            ST_OCU: begin
                if (ocu_done || w_to_fire) w_state_next = ST_REC;
            end
            ST_END:  w_state_next = ST_END;
            default: w_state_next = ST_REC;
        endcase
        if (tag_status) begin
            w_state_next = ST_END;
        end
    end

    // Guard counter is loaded on entry to a guard state, then counts down to zero.
    always_comb begin
        w_grd_load     = 1'b0;
        w_grd_load_val = G1_LOAD;
        if ((w_state_next == ST_GRD1) && (r_state != ST_GRD1)) begin
            w_grd_load     = 1'b1;
            w_grd_load_val = G1_LOAD;
        end else if ((w_state_next == ST_GRD2) && (r_state != ST_GRD2)) begin
            w_grd_load     = 1'b1;
            w_grd_load_val = G2_LOAD;
        end
    end

    assign w_grd_en = (r_state == ST_GRD1) || (r_state == ST_GRD2);
    assign w_wd_clr = (w_state_next != r_state);

    pmu_dly_cnt #(.W(GW)) u_guard_cnt (
        .i_clk      (DOUB_BLF),
        .i_srst     (rst),
        .i_clr      (1'b0),
        .i_load     (w_grd_load),
        .i_load_val (w_grd_load_val),
        .i_en       (w_grd_en),
        .i_up       (1'b0),
        .i_tc_val   ('0),
        .o_tc       (w_grd_tc)
    );

    pmu_dly_cnt #(.W(TO_W)) u_wd_cnt (
        .i_clk      (DOUB_BLF),
        .i_srst     (rst),
        .i_clr      (w_wd_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_in_stage),
        .i_up       (1'b1),
        .i_tc_val   (WD_TC),
        .o_tc       (w_wd_tc)
    );

    // Clock gating: divider off wins over request, 60 kHz request wins over off.
    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            r_div_en <= 1'b1;
            r_k60_en <= 1'b0;
        end else begin
            if (new_cmd || par_div_off) r_div_en <= 1'b0;
            else if (par_div_req || dec_done) r_div_en <= 1'b1;
            if (ie_60k_req) r_k60_en <= 1'b1;
            else if (ie_60k_off) r_k60_en <= 1'b0;
        end
    end

    // VEE request/check flags; a fresh dec_done outranks any simultaneous clear.
    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            r_vee_req  <= 1'b0;
            r_vchk_en  <= 1'b0;
            r_vee_err  <= 1'b0;
            r_stage_to <= 1'b0;
        end else begin
            r_stage_to <= w_to_fire;
            if (dec_done) r_vee_req <= w_wr_come;
            else if (ocu_done || w_to_fire) r_vee_req <= 1'b0;
            if (dec_done) r_vchk_en <= w_wr_come;
            else if (scu_done || w_to_fire) r_vchk_en <= 1'b0;
            if (scu_done) r_vee_err <= r_vchk_en && !w_vee_ok;
        end
    end

    // Stability counter: consecutive vee_rdy cycles, saturating at the window length.
    always_ff @(posedge DOUB_BLF) begin
        if (rst) begin
            r_stab <= '0;
        end else if (!vee_rdy) begin
            r_stab <= '0;
        end else if (r_stab != VCHK_FULL) begin
            r_stab <= r_stab + 1'b1;
        end
    end

    assign init_en     = (r_state == ST_INIT);
    assign dec_en      = (r_state == ST_REC);
    assign scu_en      = (r_state == ST_SCU);
    assign ocu_en      = (r_state == ST_OCU);
    assign div_en      = r_div_en;
    assign K60_EN      = r_k60_en;
    assign vee_req     = r_vee_req;
    assign vchk_en     = r_vchk_en;
    assign vee_err     = r_vee_err;
    assign stage_to    = r_stage_to;
    assign pmu_state_o = r_state;

endmodule
